// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Shares one register-file write port between two writeback
//                sources. Port A (single-cycle datapath) has priority; port B
//                (long-latency unit) results queue in a 2-entry FIFO and drain
//                into idle slots. A saturating starve counter forces a B drain
//                after STARVE_MAX consecutive A wins with B waiting, and a
//                younger A write kills queued older B writes to the same
//                register (WAW ordering).
//  Ports       : clk, rst                     - clock, sync active-high reset
//                a_valid/a_addr/a_data/a_ready - port A request + accept
//                b_valid/b_addr/b_data/b_ready - port B request + FIFO space
//                we/waddr/wdata                - registered register-file write
//                b_pending                     - FIFO non-empty (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          b_pending
);

    localparam logic [2:0] c_starve_max = 3'(STARVE_MAX);

    // FIFO is kept as a shift register: entry 0 is always the head.
    logic [AW-1:0] r_fifo_addr [2];
    logic [DW-1:0] r_fifo_data [2];
    logic [1:0]    r_fifo_kill;
    logic [1:0]    r_count;
    logic [2:0]    r_starve;

    logic          w_nonempty;
    logic          w_force;
    logic          w_grant_a;
    logic          w_pop;
    logic          w_push;
    logic          w_wr_idx;
    logic [1:0]    w_kill_hit;

    assign w_nonempty = (r_count != 2'd0);
    assign w_force    = w_nonempty && (r_starve == c_starve_max);
    assign a_ready    = ~w_force;
    assign b_ready    = (r_count < 2'd2);
    assign w_grant_a  = a_valid && ~w_force;
    // Any cycle that is not an A grant drains the head if one exists.
    assign w_pop      = w_nonempty && ~w_grant_a;
    assign w_push     = b_valid && b_ready;
    // Pop happens before push, so the new entry lands behind the survivor.
    assign w_wr_idx   = (r_count == 2'd1) && ~w_pop;
    assign b_pending  = w_nonempty;

    // Only entries resident before this cycle can be killed; a same-cycle
    // push is younger than the A write and survives.
    for (genvar gi = 0; gi < 2; gi++) begin : g_kill
        assign w_kill_hit[gi] = w_grant_a && (a_addr != '0) &&
                                (r_count > 2'(gi)) &&
                                (r_fifo_addr[gi] == a_addr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= 2'd0;
            r_fifo_kill <= 2'b00;
            r_starve    <= 3'd0;
            we          <= 1'b0;
            waddr       <= '0;
            wdata       <= '0;
        end else begin
            // FIFO contents: kill marking, then shift on pop, then push.
            if (w_pop) begin
                r_fifo_addr[0] <= r_fifo_addr[1];
                r_fifo_data[0] <= r_fifo_data[1];
                r_fifo_kill[0] <= r_fifo_kill[1];
            end else begin
                r_fifo_kill <= r_fifo_kill | w_kill_hit;
            end
            if (w_push) begin
                r_fifo_addr[w_wr_idx] <= b_addr;
                r_fifo_data[w_wr_idx] <= b_data;
                r_fifo_kill[w_wr_idx] <= 1'b0;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

            // Starve counter counts A wins only while B is waiting.
            if (w_pop || !w_nonempty) begin
                r_starve <= 3'd0;
            end else if (w_grant_a && (r_starve < c_starve_max)) begin
                r_starve <= r_starve + 3'd1;
            end

            // Registered write port; waddr/wdata hold when idle.
            if (w_grant_a) begin
                we    <= (a_addr != '0);
                waddr <= a_addr;
                wdata <= a_data;
            end else if (w_pop) begin
                we    <= (r_fifo_addr[0] != '0) && ~r_fifo_kill[0];
                waddr <= r_fifo_addr[0];
                wdata <= r_fifo_data[0];
            end else begin
                we    <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Directed self-checking bench for regfile_wb_arbiter
//                (AW=5, DW=32, STARVE_MAX=3) with hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic [4:0]  a_addr  = '0;
    logic [31:0] a_data  = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [4:0]  b_addr  = '0;
    logic [31:0] b_data  = '0;
    logic        b_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        b_pending;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(.AW(5), .DW(32), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .b_pending(b_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive inputs, then let combinational outputs settle before checks.
    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        // ---------------- reset ----------------
        tick(); tick();
        rst = 1'b0;
        idle();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd1);
        chk("rst_a_ready", 32'(a_ready), 32'd1);
        chk("rst_b_pending", 32'(b_pending), 32'd0);

        // ---------------- A only ----------------
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        tick();
        chk("a_we", 32'(we), 32'd1);
        chk("a_waddr", 32'(waddr), 32'd5);
        chk("a_wdata", wdata, 32'h1234);
        drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
        tick();
        chk("a_r0_we", 32'(we), 32'd0);

        // ---------------- B idle path ----------------
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hBEEF);
        chk("bidle_b_ready", 32'(b_ready), 32'd1);
        tick();
        idle();
        chk("bidle_pending", 32'(b_pending), 32'd1);
        chk("bidle_we_early", 32'(we), 32'd0);
        tick();
        chk("bidle_we", 32'(we), 32'd1);
        chk("bidle_waddr", 32'(waddr), 32'd7);
        chk("bidle_wdata", wdata, 32'hBEEF);
        chk("bidle_pending_clr", 32'(b_pending), 32'd0);

        // ---------------- starvation ----------------
        // B r2 queued alongside an A grant; then A wins 3 times with B waiting.
        drive(1'b1, 5'd1, 32'h10, 1'b1, 5'd2, 32'h22);
        tick();
        chk("stv_we0", 32'(waddr), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 5'd1, 32'h10 + 32'(i), 1'b0, 5'd0, 32'd0);
            chk("stv_a_ready", 32'(a_ready), 32'd1);
            tick();
            chk("stv_a_we", 32'(we), 32'd1);
            chk("stv_a_wdata", wdata, 32'h10 + 32'(i));
        end
        drive(1'b1, 5'd1, 32'h14, 1'b0, 5'd0, 32'd0);
        chk("stv_forced_a_ready", 32'(a_ready), 32'd0);
        tick();
        chk("stv_b_we", 32'(we), 32'd1);
        chk("stv_b_waddr", 32'(waddr), 32'd2);
        chk("stv_b_wdata", wdata, 32'h22);
        chk("stv_a_ready_back", 32'(a_ready), 32'd1);
        tick();
        chk("stv_a_resume", wdata, 32'h14);
        idle();

        // ---------------- full FIFO ----------------
        drive(1'b1, 5'd3, 32'h30, 1'b1, 5'd10, 32'hA0);
        tick();
        drive(1'b1, 5'd3, 32'h31, 1'b1, 5'd11, 32'hA1);
        chk("full_b_ready_1", 32'(b_ready), 32'd1);
        tick();
        drive(1'b1, 5'd3, 32'h32, 1'b1, 5'd12, 32'hA2);
        chk("full_b_ready_0", 32'(b_ready), 32'd0);
        chk("full_pending", 32'(b_pending), 32'd1);
        tick();
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'hA2);
        chk("full_b_ready_still0", 32'(b_ready), 32'd0);
        tick();
        drive(1'b1, 5'd3, 32'h34, 1'b1, 5'd12, 32'hA2);
        chk("full_force_a_ready", 32'(a_ready), 32'd0);
        chk("full_force_b_ready", 32'(b_ready), 32'd0);
        tick();
        chk("full_drain_waddr", 32'(waddr), 32'd10);
        chk("full_drain_wdata", wdata, 32'hA0);
        drive(1'b1, 5'd3, 32'h34, 1'b1, 5'd12, 32'hA2);
        chk("full_b_ready_after_drain", 32'(b_ready), 32'd1);
        tick();
        idle();
        chk("full_a_after", wdata, 32'h34);
        tick();
        chk("full_drain2_waddr", 32'(waddr), 32'd11);
        tick();
        chk("full_drain3_we", 32'(we), 32'd1);
        chk("full_drain3_waddr", 32'(waddr), 32'd12);
        chk("full_drain3_wdata", wdata, 32'hA2);
        chk("full_empty", 32'(b_pending), 32'd0);

        // ---------------- WAW kill ----------------
        drive(1'b1, 5'd4, 32'h40, 1'b1, 5'd9, 32'h1);
        tick();
        drive(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0);
        tick();
        idle();
        chk("waw_a_we", 32'(we), 32'd1);
        chk("waw_a_wdata", wdata, 32'h2);
        tick();
        chk("waw_killed_we", 32'(we), 32'd0);
        chk("waw_killed_empty", 32'(b_pending), 32'd0);
        // Same-cycle A and B to r9: B is younger and must land afterwards.
        drive(1'b1, 5'd9, 32'h3, 1'b1, 5'd9, 32'h4);
        tick();
        idle();
        chk("waw_same_a", wdata, 32'h3);
        tick();
        chk("waw_same_b_we", 32'(we), 32'd1);
        chk("waw_same_b_wdata", wdata, 32'h4);

        // ---------------- mid-operation reset ----------------
        drive(1'b1, 5'd6, 32'h60, 1'b1, 5'd13, 32'hD0);
        tick();
        drive(1'b1, 5'd6, 32'h61, 1'b1, 5'd14, 32'hE0);
        tick();
        idle();
        chk("mrst_queued", 32'(b_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_pending", 32'(b_pending), 32'd0);
        chk("mrst_we", 32'(we), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_no_b_write", 32'(we), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
